bit_serial_operand_feeder: RTL and testbench
============================================

BIT_SERIAL_OPERAND_FEEDER -- requirements
Module: bit_serial_operand_feeder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand word width in bits; legal range 2..32.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  synchronous active-low reset.
REQ-005 in_valid  input  1  parallel operand pair offered.
REQ-006 in_ready  output  1  block accepts operand pair this cycle.
REQ-007 in_a  input  WIDTH  operand A, unsigned.
REQ-008 in_b  input  WIDTH  operand B, unsigned.
REQ-009 a  output  1  serial bit of A, LSB first, to the adder a input.
REQ-010 b  output  1  serial bit of B, LSB first, to the adder b input.
REQ-011 bit_valid  output  1  a/b carry a live bit this cycle.
REQ-012 first  output  1  current bit is bit 0 of a word.
REQ-013 last  output  1  current bit is bit WIDTH-1 of a word.
REQ-014 carry_clr  output  1  drives the adder's active-high reset; clears the adder carry at the next edge.

Function
REQ-015 A transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; the operands are sampled on that edge.
REQ-016 The FSM SHALL have two states: IDLE (no word shifting) and SHIFT (word being emitted).
REQ-017 IDLE -> SHIFT SHALL occur on a transfer; SHIFT -> IDLE SHALL occur after the last-bit cycle when no further word is pending.
REQ-018 Bit 0 of an accepted word SHALL appear on a/b with bit_valid=1 and first=1 in the cycle after the transfer edge (latency 1).
REQ-019 Bit k SHALL appear exactly k cycles after bit 0; one bit per cycle; no stall.
REQ-020 last SHALL be 1 only in the bit WIDTH-1 cycle; with first it SHALL never be 1 in the same cycle.
REQ-021 A bit counter of ceil(log2(WIDTH)) bits SHALL count 0..WIDTH-1 and return to 0 after WIDTH-1; no other wrap is allowed.
REQ-022 When bit_valid=0, a, b, first and last SHALL be 0.
REQ-023 carry_clr SHALL equal (bit_valid=0) OR (last=1), so the adder carry is 0 before every bit 0.
REQ-024 All outputs except in_ready and carry_clr SHALL be driven directly from registers.
REQ-025 in_valid held high with in_ready=0 SHALL cause no state change; in_a/in_b SHALL be ignored.

Reset
REQ-026 When reset_n=0 at a rising edge, the FSM SHALL enter IDLE, the counter SHALL clear, and all shift and holding registers SHALL clear.
REQ-027 After reset: bit_valid=0, first=0, last=0, a=0, b=0, carry_clr=1, in_ready=1.
REQ-028 Reset asserted mid-word SHALL discard that word and any pending word; no further bits of either are emitted.
REQ-029 in_ready SHALL be 0 while reset_n=0.

Configuration
REQ-030 The macro BIT_SERIAL_FEEDER_SKID_EN SHALL select a one-entry holding register.
REQ-031 Without BIT_SERIAL_FEEDER_SKID_EN, in_ready SHALL be 1 only in IDLE; consecutive words are separated by exactly one bubble cycle (bit_valid=0, carry_clr=1).
REQ-032 With BIT_SERIAL_FEEDER_SKID_EN, in_ready SHALL be 1 whenever the holding register is empty, including during SHIFT.
REQ-033 With BIT_SERIAL_FEEDER_SKID_EN, a word accepted during SHIFT SHALL be held and SHALL load into the shifter on the last-bit edge; its bit 0 follows the previous word's last bit with no gap.
REQ-034 With BIT_SERIAL_FEEDER_SKID_EN, a transfer on the last-bit edge with an empty holder SHALL load the shifter directly, with no gap.
REQ-035 With BIT_SERIAL_FEEDER_SKID_EN, the holder SHALL empty on the edge where it loads the shifter.

Verification
REQ-036 WIDTH=8, reset, then transfer A=0xA5, B=0x3C -> next cycle first=1, a=1, b=0; bit sequence matches LSB first; last=1 at cycle 8.
REQ-037 A=0xFF, B=0x01 feeding the adder -> collected sum bits 0x00; carry_clr=1 at last, so the next word starts with carry 0.
REQ-038 Without the macro: in_valid held high with two words -> a 1-cycle bubble between last and first, and in_ready=0 throughout SHIFT.
REQ-039 With the macro: three back-to-back words -> 24 consecutive bit_valid cycles, first every 8 cycles, in_ready=0 only while the holder is full.
REQ-040 reset_n=0 at bit 3 of a word -> next cycle bit_valid=0, carry_clr=1, in_ready=0; after release, in_ready=1 and no stale bits appear.
REQ-041 WIDTH=2 -> first and last alternate on consecutive cycles; the counter never exceeds 1.

Source files
------------

// File: rtl/bit_serial_operand_feeder_if.sv
// Operand-pair handshake in, LSB-first bit pair out, for the serial feeder.
// master drives the parallel operands; slave is the feeder itself.
interface bit_serial_operand_feeder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             a;
  logic             b;
  logic             bit_valid;
  logic             first;
  logic             last;
  logic             carry_clr;

  modport master (
    output in_valid, in_a, in_b,
    input  in_ready, a, b, bit_valid,
    input  first, last, carry_clr
  );

  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready, a, b, bit_valid,
    output first, last, carry_clr
  );
endinterface

// File: rtl/bit_serial_operand_feeder.sv
// Serialises an operand pair LSB first into a bit-serial adder.
// Define BIT_SERIAL_FEEDER_SKID_EN for a one-entry holder (gapless words).
module bit_serial_operand_feeder #(
  parameter int WIDTH = 8
) (
  input logic                   clk,
  input logic                   reset_n,
  bit_serial_operand_feeder_if.slave io
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] MAX = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             xfer;
  logic             load;
  logic [WIDTH-1:0] ld_a, ld_b;

`ifdef BIT_SERIAL_FEEDER_SKID_EN
  logic [WIDTH-1:0] ha_q, ha_d;
  logic [WIDTH-1:0] hb_q, hb_d;
  logic             hf_q, hf_d;

  assign io.in_ready = reset_n & ~hf_q;
`else
  assign io.in_ready = reset_n & (state_q == IDLE);
`endif

  assign xfer = io.in_valid & io.in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    first_d = first_q;
    last_d  = last_q;
    load    = 1'b0;
    ld_a    = io.in_a;
    ld_b    = io.in_b;
`ifdef BIT_SERIAL_FEEDER_SKID_EN
    ha_d    = ha_q;
    hb_d    = hb_q;
    hf_d    = hf_q;
`endif
    unique case (state_q)
      IDLE: load = xfer;
      SHIFT: begin
        if (cnt_q == MAX) begin
`ifdef BIT_SERIAL_FEEDER_SKID_EN
          // a held word takes priority; it blocks new transfers anyway
          if (hf_q) begin
            load = 1'b1;
            ld_a = ha_q;
            ld_b = hb_q;
            hf_d = 1'b0;
            ha_d = '0;
            hb_d = '0;
          end else begin
            load = xfer;
          end
`endif
          if (!load) begin
            state_d = IDLE;
            cnt_d   = '0;
            sa_d    = '0;
            sb_d    = '0;
            first_d = 1'b0;
            last_d  = 1'b0;
          end
        end else begin
          cnt_d   = cnt_q + CW'(1);
          sa_d    = sa_q >> 1;
          sb_d    = sb_q >> 1;
          first_d = 1'b0;
          last_d  = (cnt_q == MAX - CW'(1));
`ifdef BIT_SERIAL_FEEDER_SKID_EN
          if (xfer) begin
            hf_d = 1'b1;
            ha_d = io.in_a;
            hb_d = io.in_b;
          end
`endif
        end
      end
    endcase
    if (load) begin
      state_d = SHIFT;
      cnt_d   = '0;
      sa_d    = ld_a;
      sb_d    = ld_b;
      first_d = 1'b1;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
`ifdef BIT_SERIAL_FEEDER_SKID_EN
      ha_q    <= '0;
      hb_q    <= '0;
      hf_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      first_q <= first_d;
      last_q  <= last_d;
`ifdef BIT_SERIAL_FEEDER_SKID_EN
      ha_q    <= ha_d;
      hb_q    <= hb_d;
      hf_q    <= hf_d;
`endif
    end
  end

  assign io.a         = sa_q[0];
  assign io.b         = sb_q[0];
  assign io.bit_valid = (state_q == SHIFT);
  assign io.first     = first_q;
  assign io.last      = last_q;
  assign io.carry_clr = (state_q == IDLE) | last_q;
endmodule

// File: tb/tb_bit_serial_operand_feeder.sv
// Directed bench for bit_serial_operand_feeder (WIDTH=8 and WIDTH=2).
// Follows BIT_SERIAL_FEEDER_SKID_EN when defined.
module tb_bit_serial_operand_feeder;
`ifdef BIT_SERIAL_FEEDER_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  bit_serial_operand_feeder_if #(.WIDTH(8)) f8 ();
  bit_serial_operand_feeder_if #(.WIDTH(2)) f2 ();

  bit_serial_operand_feeder #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(reset_n), .io(f8.slave)
  );
  bit_serial_operand_feeder #(.WIDTH(2)) u2 (
    .clk(clk), .reset_n(reset_n), .io(f2.slave)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  logic cy    = 1'b0;
  logic cy_n;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // external serial adder carry, cleared by carry_clr
  task automatic tick();
    cy_n = f8.carry_clr ? 1'b0
         : ((f8.a & f8.b) | (f8.a & cy) | (f8.b & cy));
    @(posedge clk);
    cy = cy_n;
    #1;
  endtask

  function automatic logic [4:0] fl8();
    return {f8.bit_valid, f8.first, f8.last, f8.carry_clr, f8.in_ready};
  endfunction

  task automatic chk_bit(input string tag, input int k,
                         input logic [7:0] wa, input logic [7:0] wb,
                         input logic rdy);
    chk({tag, "_flags"}, 32'(fl8()),
        32'({1'b1, k == 0, k == 7, k == 7, rdy}));
    chk({tag, "_ab"}, 32'({f8.a, f8.b}), 32'({wa[k], wb[k]}));
  endtask

  logic [7:0] sum;
  logic       stale;
  logic       go;
  int         sent;
  logic [7:0] wa3 [3];
  logic [7:0] wb3 [3];
  logic [4:0] exp2 [6];

  initial begin
    reset_n     = 1'b0;
    f8.in_valid = 1'b0;
    f8.in_a     = '0;
    f8.in_b     = '0;
    f2.in_valid = 1'b0;
    f2.in_a     = '0;
    f2.in_b     = '0;

    tick();
    chk("ready_in_reset", 32'(f8.in_ready), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_reset",
        32'({f8.bit_valid, f8.first, f8.last, f8.a, f8.b,
             f8.carry_clr, f8.in_ready}), 32'b0000011);

    // basic word
    f8.in_valid = 1'b1;
    f8.in_a = 8'hA5;
    f8.in_b = 8'h3C;
    tick();
    f8.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk_bit("w_a5", k, 8'hA5, 8'h3C, SKID);
      if (k < 7) tick();
    end
    tick();
    chk("idle_after_a5", 32'(fl8()), 32'b00011);

    // adder: 0xFF + 0x01 truncated to 8 bits
    f8.in_valid = 1'b1;
    f8.in_a = 8'hFF;
    f8.in_b = 8'h01;
    tick();
    f8.in_valid = 1'b0;
    sum = '0;
    for (int k = 0; k < 8; k++) begin
      sum[k] = f8.a ^ f8.b ^ cy;
      chk_bit("w_add", k, 8'hFF, 8'h01, SKID);
      if (k < 7) tick();
    end
    chk("sum", 32'(sum), 32'h00);
    tick();
    chk("carry_cleared", 32'(cy), 32'h0);

`ifndef BIT_SERIAL_FEEDER_SKID_EN
    // held in_valid: second word waits, one bubble between words
    f8.in_valid = 1'b1;
    f8.in_a = 8'h11;
    f8.in_b = 8'h22;
    tick();
    f8.in_a = 8'h5A;
    f8.in_b = 8'hC3;
    for (int k = 0; k < 8; k++) begin
      chk_bit("w1", k, 8'h11, 8'h22, 1'b0);
      if (k < 7) tick();
    end
    tick();
    chk("bubble", 32'(fl8()), 32'b00011);
    tick();
    f8.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk_bit("w2", k, 8'h5A, 8'hC3, 1'b0);
      if (k < 7) tick();
    end
    tick();
    chk("idle_after_w2", 32'(fl8()), 32'b00011);
`else
    // three words back to back through the holder
    wa3 = '{8'h96, 8'h3B, 8'hE1};
    wb3 = '{8'h0F, 8'hC4, 8'h7D};
    sent = 0;
    f8.in_valid = 1'b1;
    f8.in_a = wa3[0];
    f8.in_b = wb3[0];
    go = f8.in_valid & f8.in_ready;
    tick();
    if (go) sent++;
    f8.in_valid = (sent < 3);
    if (sent < 3) begin
      f8.in_a = wa3[sent];
      f8.in_b = wb3[sent];
    end
    for (int n = 0; n < 24; n++) begin
      chk_bit("skid", n % 8, wa3[n / 8], wb3[n / 8],
              !((n >= 1 && n <= 7) || (n >= 9 && n <= 15)));
      go = f8.in_valid & f8.in_ready;
      if (n < 23) begin
        tick();
        if (go) sent++;
        f8.in_valid = (sent < 3);
        if (sent < 3) begin
          f8.in_a = wa3[sent];
          f8.in_b = wb3[sent];
        end
      end
    end
    tick();
    chk("skid_idle", 32'(fl8()), 32'b00011);
    chk("skid_sent", 32'(sent), 32'd3);
`endif

    // reset in the middle of a word
    f8.in_valid = 1'b1;
    f8.in_a = 8'hF0;
    f8.in_b = 8'h0F;
    tick();
    f8.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk_bit("w_rst", k, 8'hF0, 8'h0F, SKID);
      if (k < 3) tick();
    end
    reset_n = 1'b0;
    #1;
    chk("ready_drops", 32'(f8.in_ready), 32'h0);
    tick();
    chk("mid_reset",
        32'({f8.bit_valid, f8.carry_clr, f8.in_ready}), 32'b010);
    reset_n = 1'b1;
    tick();
    chk("after_release", 32'(fl8()), 32'b00011);
    stale = 1'b0;
    for (int i = 0; i < 10; i++) begin
      stale = stale | f8.bit_valid | f8.a | f8.b;
      tick();
    end
    chk("no_stale", 32'(stale), 32'h0);

    // WIDTH=2 with in_valid held high
    if (SKID)
      exp2 = '{5'b11001, 5'b10110, 5'b11001,
               5'b10110, 5'b11001, 5'b10110};
    else
      exp2 = '{5'b11001, 5'b10110, 5'b00000,
               5'b11001, 5'b10110, 5'b00000};
    f2.in_valid = 1'b1;
    f2.in_a = 2'b10;
    f2.in_b = 2'b01;
    tick();
    for (int n = 0; n < 6; n++) begin
      chk($sformatf("w2bit_%0d", n),
          32'({f2.bit_valid, f2.first, f2.last, f2.a, f2.b}),
          32'(exp2[n]));
      tick();
    end
    f2.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("w2_idle",
        32'({f2.bit_valid, f2.first, f2.last, f2.carry_clr, f2.in_ready}),
        32'b00011);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
